// File: rtl/chip8_alu_seq_if.sv
// Request/response bundle between the CPU control FSM and chip8_alu_seq.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface chip8_alu_seq_if #(
    parameter int WIDTH      = 8,
    parameter int BCD_DIGITS = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              op;
    logic [WIDTH-1:0]        a;
    logic [WIDTH-1:0]        b;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        result;
    logic                    flag;
    logic                    flag_we;
    logic [4*BCD_DIGITS-1:0] bcd;
    logic                    err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag, flag_we, bcd, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag, flag_we, bcd, err
    );
endinterface

// File: rtl/chip8_alu_seq.sv
// Chip-8 8XYn ALU with exact VF semantics plus shift-add-3 binary-to-BCD for FX33.
// Latency: result in the cycle after accept; BCD result WIDTH cycles after accept.
// Backpressure: one op in flight; result held until out_ready, in_ready only while idle.
module chip8_alu_seq #(
    parameter int WIDTH      = 8,   // legal 4..16
    parameter int BCD_DIGITS = 3    // 10**BCD_DIGITS must exceed 2**WIDTH-1
) (
    input  logic           clk,
    input  logic           reset,
    chip8_alu_seq_if.slave bus
);
    localparam int BW = 4 * BCD_DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_BCD, S_DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             flag;
        logic             flag_we;
        logic             err;
    } alu_out_t;

    state_t          state_q, state_d;
    alu_out_t        out_q, alu_d;
    logic [BW-1:0]   bcd_q;
    logic [SW-1:0]   shreg_q, bcd_adj, bcd_shifted;
    logic [CW-1:0]   cnt_q;
    logic [WIDTH:0]  sum;
    logic            accept;

    assign accept = bus.in_valid && (state_q == S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (bus.op == 4'hF) ? S_BCD : S_DONE;
            S_BCD:   if (cnt_q == CW'(1)) state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.result    = out_q.result;
        bus.flag      = out_q.flag;
        bus.flag_we   = out_q.flag_we;
        bus.err       = out_q.err;
        bus.bcd       = bcd_q;
    end

    // Single-cycle ops; BCD reports a unchanged with no VF write.
    always_comb begin
        sum   = {1'b0, bus.a} + {1'b0, bus.b};
        alu_d = '0;
        case (bus.op)
            4'h0: alu_d.result = bus.b;
            4'h1: alu_d.result = bus.a | bus.b;
            4'h2: alu_d.result = bus.a & bus.b;
            4'h3: alu_d.result = bus.a ^ bus.b;
            4'h4: begin
                alu_d.result  = sum[WIDTH-1:0];
                alu_d.flag    = sum[WIDTH];
                alu_d.flag_we = 1'b1;
            end
            4'h5: begin
                alu_d.result  = bus.a - bus.b;
                alu_d.flag    = (bus.a >= bus.b);
                alu_d.flag_we = 1'b1;
            end
            4'h6: begin
                alu_d.result  = bus.a >> 1;
                alu_d.flag    = bus.a[0];
                alu_d.flag_we = 1'b1;
            end
            4'h7: begin
                alu_d.result  = bus.b - bus.a;
                alu_d.flag    = (bus.b >= bus.a);
                alu_d.flag_we = 1'b1;
            end
            4'h8: alu_d.result = bus.a + WIDTH'(1);
            4'hE: begin
                alu_d.result  = bus.a << 1;
                alu_d.flag    = bus.a[WIDTH-1];
                alu_d.flag_we = 1'b1;
            end
            4'hF: alu_d.result = bus.a;
            default: alu_d.err = 1'b1;
        endcase
    end

    // Double-dabble step: correct every digit >= 5 before the shift so it carries as decimal.
    always_comb begin
        bcd_adj = shreg_q;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd_adj[WIDTH + 4*d +: 4] >= 4'd5)
                bcd_adj[WIDTH + 4*d +: 4] = bcd_adj[WIDTH + 4*d +: 4] + 4'd3;
        end
        bcd_shifted = bcd_adj << 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            bcd_q   <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            out_q <= alu_d;
            bcd_q <= '0;
            if (bus.op == 4'hF) begin
                shreg_q <= {{BW{1'b0}}, bus.a};
                cnt_q   <= CW'(WIDTH);
            end
        end else if (state_q == S_BCD) begin
            shreg_q <= bcd_shifted;
            cnt_q   <= cnt_q - CW'(1);
            if (cnt_q == CW'(1))
                bcd_q <= bcd_shifted[SW-1 -: BW];
        end
    end
endmodule

// File: tb/tb_chip8_alu_seq.sv
// Bench for chip8_alu_seq: directed vector table, reference-model random ops, reset and backpressure corners.
// Runs an 8-bit/3-digit and a 12-bit/4-digit instance side by side.
module tb_chip8_alu_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid8 = 1'b0, valid12 = 1'b0, rdy_d = 1'b0, sel = 1'b0;
    logic [3:0]  op_d = '0;
    logic [15:0] a_d = '0, b_d = '0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    chip8_alu_seq_if #(.WIDTH(8),  .BCD_DIGITS(3)) bus8 ();
    chip8_alu_seq_if #(.WIDTH(12), .BCD_DIGITS(4)) bus12 ();

    assign bus8.in_valid   = valid8;
    assign bus8.op         = op_d;
    assign bus8.a          = a_d[7:0];
    assign bus8.b          = b_d[7:0];
    assign bus8.out_ready  = rdy_d;
    assign bus12.in_valid  = valid12;
    assign bus12.op        = op_d;
    assign bus12.a         = a_d[11:0];
    assign bus12.b         = b_d[11:0];
    assign bus12.out_ready = rdy_d;

    chip8_alu_seq #(.WIDTH(8),  .BCD_DIGITS(3)) dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));
    chip8_alu_seq #(.WIDTH(12), .BCD_DIGITS(4)) dut12 (.clk(clk), .reset(reset), .bus(bus12.slave));

    logic        ov, ir, fl, we, er;
    logic [15:0] rs, bc;
    assign ov = sel ? bus12.out_valid : bus8.out_valid;
    assign ir = sel ? bus12.in_ready  : bus8.in_ready;
    assign fl = sel ? bus12.flag      : bus8.flag;
    assign we = sel ? bus12.flag_we   : bus8.flag_we;
    assign er = sel ? bus12.err       : bus8.err;
    assign rs = sel ? 16'(bus12.result) : 16'(bus8.result);
    assign bc = sel ? 16'(bus12.bcd)    : 16'(bus8.bcd);

    typedef struct {
        int res;
        int flag;
        int we;
        int bcd;
        int err;
        int edges;   // rising edges after the accept edge before out_valid is seen
    } obs_t;

    typedef struct {
        logic [3:0] op;
        int         a;
        int         b;
        obs_t       exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: Chip-8 rules in plain integer arithmetic.
    function automatic obs_t model(input int w, input int nd, input logic [3:0] op, input int a, input int b);
        obs_t o;
        int   m, v;
        m = 1 << w;
        o = '{default: 0};
        case (op)
            4'h0: o.res = b;
            4'h1: o.res = a | b;
            4'h2: o.res = a & b;
            4'h3: o.res = a ^ b;
            4'h4: begin o.res = (a + b) % m; o.flag = (a + b >= m) ? 1 : 0; o.we = 1; end
            4'h5: begin o.res = (a - b + m) % m; o.flag = (a >= b) ? 1 : 0; o.we = 1; end
            4'h6: begin o.res = a / 2; o.flag = a % 2; o.we = 1; end
            4'h7: begin o.res = (b - a + m) % m; o.flag = (b >= a) ? 1 : 0; o.we = 1; end
            4'h8: o.res = (a + 1) % m;
            4'hE: begin o.res = (a * 2) % m; o.flag = (a >= m / 2) ? 1 : 0; o.we = 1; end
            4'hF: begin
                o.res = a;
                o.edges = w;
                v = a;
                for (int d = 0; d < nd; d++) begin
                    o.bcd = o.bcd | ((v % 10) << (4 * d));
                    v = v / 10;
                end
            end
            default: o.err = 1;
        endcase
        return o;
    endfunction

    // Issue one op, wait (bounded) for the result, hold it for 'hold' cycles, then release.
    task automatic run(input logic s, input logic [3:0] o, input int av, input int bv,
                       input int hold, output obs_t got);
        bit busy_ok;
        sel = s;
        @(negedge clk);
        chk("in_ready_idle", {31'd0, ir}, 32'd1);
        op_d = o; a_d = 16'(av); b_d = 16'(bv);
        if (s) valid12 = 1'b1; else valid8 = 1'b1;
        @(posedge clk);
        #1;
        valid8 = 1'b0; valid12 = 1'b0;
        op_d = ~o; a_d = 16'($urandom); b_d = 16'($urandom);
        got = '{default: 0};
        busy_ok = 1'b1;
        @(negedge clk);
        while (!ov && got.edges < 100) begin
            if (ir) busy_ok = 1'b0;
            @(negedge clk);
            got.edges++;
        end
        repeat (hold) begin
            if (ir) busy_ok = 1'b0;
            @(negedge clk);
        end
        chk("in_ready_low_while_busy", {31'd0, busy_ok}, 32'd1);
        chk("out_valid_held", {31'd0, ov}, 32'd1);
        got.res = rs; got.flag = fl; got.we = we; got.bcd = bc; got.err = er;
        rdy_d = 1'b1;
        @(posedge clk);
        #1 rdy_d = 1'b0;
    endtask

    task automatic cmp(input string name, input obs_t got, input obs_t exp);
        chk({name, ".result"},  got.res,   exp.res);
        chk({name, ".flag"},    got.flag,  exp.flag);
        chk({name, ".flag_we"}, got.we,    exp.we);
        chk({name, ".bcd"},     got.bcd,   exp.bcd);
        chk({name, ".err"},     got.err,   exp.err);
        chk({name, ".latency"}, got.edges, exp.edges);
    endtask

    vec_t vecs[$];
    obs_t got;
    bit   seen;

    initial begin
        //               op     a      b      res   flag we bcd    err edges
        vecs.push_back('{4'h4, 'hFF, 'h01, '{'h00, 1, 1, 0,     0, 0}});
        vecs.push_back('{4'h5, 'h05, 'h05, '{'h00, 1, 1, 0,     0, 0}});
        vecs.push_back('{4'h5, 'h03, 'h05, '{'hFE, 0, 1, 0,     0, 0}});
        vecs.push_back('{4'h7, 'h03, 'h05, '{'h02, 1, 1, 0,     0, 0}});
        vecs.push_back('{4'h6, 'h81, 'h00, '{'h40, 1, 1, 0,     0, 0}});
        vecs.push_back('{4'hE, 'h81, 'h00, '{'h02, 1, 1, 0,     0, 0}});
        vecs.push_back('{4'hE, 'h7F, 'h00, '{'hFE, 0, 1, 0,     0, 0}});
        vecs.push_back('{4'h2, 'hF0, 'h3C, '{'h30, 0, 0, 0,     0, 0}});
        vecs.push_back('{4'h1, 'hF0, 'h0F, '{'hFF, 0, 0, 0,     0, 0}});
        vecs.push_back('{4'h3, 'hFF, 'h0F, '{'hF0, 0, 0, 0,     0, 0}});
        vecs.push_back('{4'h0, 'h12, 'hAB, '{'hAB, 0, 0, 0,     0, 0}});
        vecs.push_back('{4'h8, 'hFF, 'h00, '{'h00, 0, 0, 0,     0, 0}});
        vecs.push_back('{4'hF, 'hFE, 'h00, '{'hFE, 0, 0, 'h254, 0, 8}});
        vecs.push_back('{4'hF, 'h00, 'h00, '{'h00, 0, 0, 'h000, 0, 8}});
        vecs.push_back('{4'hF, 'hFF, 'h00, '{'hFF, 0, 0, 'h255, 0, 8}});
        vecs.push_back('{4'h9, 'h12, 'h34, '{'h00, 0, 0, 0,     1, 0}});
        vecs.push_back('{4'h4, 'h10, 'h20, '{'h30, 0, 1, 0,     0, 0}});

        #3;
        chk("rst.in_ready",  {31'd0, bus8.in_ready},  32'd1);
        chk("rst.out_valid", {31'd0, bus8.out_valid}, 32'd0);
        chk("rst.result",    32'(bus8.result),        32'd0);
        chk("rst.bcd",       32'(bus8.bcd),           32'd0);
        chk("rst.flags",     {29'd0, bus8.flag, bus8.flag_we, bus8.err}, 32'd0);
        chk("rst12.out_valid", {31'd0, bus12.out_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, 0, got);
            cmp($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // Reset in the middle of a conversion abandons it without a result.
        sel = 1'b0;
        @(negedge clk);
        op_d = 4'hF; a_d = 16'h00FE; valid8 = 1'b1;
        @(posedge clk);
        #1 valid8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst.out_valid", {31'd0, bus8.out_valid}, 32'd0);
        chk("midrst.result",    32'(bus8.result),        32'd0);
        chk("midrst.bcd",       32'(bus8.bcd),           32'd0);
        chk("midrst.flags",     {29'd0, bus8.flag, bus8.flag_we, bus8.err}, 32'd0);
        chk("midrst.in_ready",  {31'd0, bus8.in_ready},  32'd1);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.out_valid || !bus8.in_ready) seen = 1'b1;
        end
        chk("midrst.no_spurious", {31'd0, seen}, 32'd0);

        // Backpressure: result holds while out_ready is low; stray requests are ignored.
        sel = 1'b0;
        @(negedge clk);
        op_d = 4'h2; a_d = 16'h00F0; b_d = 16'h003C; valid8 = 1'b1;
        @(posedge clk);
        #1 op_d = 4'h4; a_d = 16'h0001; b_d = 16'h0001;
        repeat (5) begin
            @(negedge clk);
            chk("bp.out_valid", {31'd0, bus8.out_valid}, 32'd1);
            chk("bp.result",    32'(bus8.result),        32'h30);
            chk("bp.in_ready",  {31'd0, bus8.in_ready},  32'd0);
        end
        valid8 = 1'b0; rdy_d = 1'b1;
        @(posedge clk);
        #1 rdy_d = 1'b0;
        @(negedge clk);
        chk("bp.release_in_ready",  {31'd0, bus8.in_ready},  32'd1);
        chk("bp.release_out_valid", {31'd0, bus8.out_valid}, 32'd0);

        // Wide instance: 12-bit conversion, illegal opcode, err cleared by next accept.
        run(1'b1, 4'hF, 'hFFF, 0, 0, got);
        cmp("w12.bcd_fff", got, '{'hFFF, 0, 0, 'h4095, 0, 12});
        run(1'b1, 4'h9, 'h123, 'h456, 0, got);
        cmp("w12.illegal", got, '{0, 0, 0, 0, 1, 0});
        run(1'b1, 4'h4, 'h800, 'h900, 0, got);
        cmp("w12.add_clr", got, '{'h100, 1, 1, 0, 0, 0});

        for (int i = 0; i < 150; i++) begin
            logic [3:0] o;
            int av, bv, hold;
            o = 4'($urandom_range(0, 15));
            av = $urandom_range(0, 255);
            bv = $urandom_range(0, 255);
            hold = $urandom_range(0, 2);
            run(1'b0, o, av, bv, hold, got);
            cmp($sformatf("rnd8_%0d_op%0h", i, o), got, model(8, 3, o, av, bv));
        end
        for (int i = 0; i < 40; i++) begin
            logic [3:0] o;
            int av, bv;
            o = 4'($urandom_range(0, 15));
            av = $urandom_range(0, 4095);
            bv = $urandom_range(0, 4095);
            run(1'b1, o, av, bv, 1, got);
            cmp($sformatf("rnd12_%0d_op%0h", i, o), got, model(12, 4, o, av, bv));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
